// File: rtl/arp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : arp_pkg                                                      |
// | Purpose : Shared ARP constants and the ARP transmit FSM state encoding.|
// | Contents: ARP operation codes, fixed header field values, broadcast    |
// |           MAC, one-hot state type for arp_tx.                          |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package arp_pkg;

  localparam logic [15:0] ARP_REQUEST_CODE = 16'h0001;
  localparam logic [15:0] ARP_REPLY_CODE   = 16'h0002;

  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN         = 8'h06;
  localparam logic [7:0]  ARP_PLEN         = 8'h04;

  localparam logic [47:0] BROADCAST_MAC    = 48'hFFFF_FFFF_FFFF;

  // Number of bytes carrying ARP fields; everything past this is zero pad.
  localparam int          ARP_BODY_BYTES   = 28;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_WAIT = 4'b0010,
    ST_SEND = 4'b0100,
    ST_END  = 4'b1000
  } arp_state_t;

endpackage
`default_nettype wire

// File: rtl/arp_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : arp_tx_if                                                  |
// | Purpose   : Handshake and data bus between the ARP transmitter and the |
// |             MAC transmit framer.                                       |
// | Signals   : arp_tx_req      frame ready (level)                        |
// |             mac_tx_ack      1-cycle grant from the MAC                 |
// |             mac_data_req    per-byte strobe from the MAC               |
// |             arp_tx_data     payload byte                               |
// |             arp_tx_op       ARP operation for the Ethernet header      |
// |             arp_tx_dest_mac destination MAC for the Ethernet header    |
// |             arp_tx_end      1-cycle pulse after the last byte          |
// | Modports  : master = ARP transmitter, slave = MAC framer               |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface arp_tx_if;

  logic        arp_tx_req;
  logic        mac_tx_ack;
  logic        mac_data_req;
  logic [7:0]  arp_tx_data;
  logic [15:0] arp_tx_op;
  logic [47:0] arp_tx_dest_mac;
  logic        arp_tx_end;

  modport master (
    output arp_tx_req,
    output arp_tx_data,
    output arp_tx_op,
    output arp_tx_dest_mac,
    output arp_tx_end,
    input  mac_tx_ack,
    input  mac_data_req
  );

  modport slave (
    input  arp_tx_req,
    input  arp_tx_data,
    input  arp_tx_op,
    input  arp_tx_dest_mac,
    input  arp_tx_end,
    output mac_tx_ack,
    output mac_data_req
  );

endinterface
`default_nettype wire

// File: rtl/arp_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : arp_tx                                                       |
// | Purpose : Builds ARP request/reply payloads (28-byte ARP body plus     |
// |           zero pad up to FRAME_BYTES) and streams them one byte per    |
// |           MAC data strobe. Replies come from the ARP receive stage,    |
// |           requests from the upper layer; replies win ties.             |
// | Ports   : clk, rst_n (synchronous, active-low)                         |
// |           local_ip_addr / local_mac_addr   sender addresses (static)   |
// |           dest_ip_addr                     IP to resolve on request    |
// |           arp_request_req                  1-cycle request pulse       |
// |           arp_reply_req / arp_reply_ack    reply level / accept pulse  |
// |           arp_rec_source_ip/mac_addr       reply target addresses      |
// |           mac (arp_tx_if.master)           MAC transmit handshake/data |
// | Params  : FRAME_BYTES (>= 28), ACK_TIMEOUT (cycles waiting for grant)  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module arp_tx
  import arp_pkg::*;
#(
  parameter int          FRAME_BYTES = 46,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [31:0] local_ip_addr,
  input  wire logic [47:0] local_mac_addr,
  input  wire logic [31:0] dest_ip_addr,
  input  wire logic        arp_request_req,
  input  wire logic        arp_reply_req,
  output logic             arp_reply_ack,
  input  wire logic [31:0] arp_rec_source_ip_addr,
  input  wire logic [47:0] arp_rec_source_mac_addr,
  arp_tx_if.master         mac
);

  localparam int             CNT_W    = $clog2(FRAME_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  arp_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_tcnt;
  logic              r_pending;
  logic [47:0]       r_target_mac;
  logic [31:0]       r_target_ip;
  logic [15:0]       r_op;
  logic [47:0]       r_dest_mac;
  logic [7:0]        r_data;
  logic              r_tx_req;
  logic              r_tx_end;
  logic              r_reply_ack;

  logic [7:0]        w_byte;
  int                w_idx;

  // Payload byte selected by the current byte counter.
  always_comb begin
    w_byte = 8'h00;
    w_idx  = int'(r_cnt);
    case (w_idx)
      0:  w_byte = ARP_HTYPE_ETH[15:8];
      1:  w_byte = ARP_HTYPE_ETH[7:0];
      2:  w_byte = ARP_PTYPE_IPV4[15:8];
      3:  w_byte = ARP_PTYPE_IPV4[7:0];
      4:  w_byte = ARP_HLEN;
      5:  w_byte = ARP_PLEN;
      6:  w_byte = r_op[15:8];
      7:  w_byte = r_op[7:0];
      8:  w_byte = local_mac_addr[47:40];
      9:  w_byte = local_mac_addr[39:32];
      10: w_byte = local_mac_addr[31:24];
      11: w_byte = local_mac_addr[23:16];
      12: w_byte = local_mac_addr[15:8];
      13: w_byte = local_mac_addr[7:0];
      14: w_byte = local_ip_addr[31:24];
      15: w_byte = local_ip_addr[23:16];
      16: w_byte = local_ip_addr[15:8];
      17: w_byte = local_ip_addr[7:0];
      18: w_byte = r_target_mac[47:40];
      19: w_byte = r_target_mac[39:32];
      20: w_byte = r_target_mac[31:24];
      21: w_byte = r_target_mac[23:16];
      22: w_byte = r_target_mac[15:8];
      23: w_byte = r_target_mac[7:0];
      24: w_byte = r_target_ip[31:24];
      25: w_byte = r_target_ip[23:16];
      26: w_byte = r_target_ip[15:8];
      27: w_byte = r_target_ip[7:0];
      default: w_byte = 8'h00;  // zero pad up to FRAME_BYTES
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_tcnt       <= '0;
      r_pending    <= 1'b0;
      r_target_mac <= '0;
      r_target_ip  <= '0;
      r_op         <= '0;
      r_dest_mac   <= '0;
      r_data       <= '0;
      r_tx_req     <= 1'b0;
      r_tx_end     <= 1'b0;
      r_reply_ack  <= 1'b0;
    end else begin
      r_reply_ack <= 1'b0;
      r_tx_end    <= 1'b0;
      // Request pulses collapse into one pending flag; cleared on accept below.
      r_pending   <= r_pending | arp_request_req;

      case (r_state)
        ST_IDLE: begin
          r_cnt  <= '0;
          r_tcnt <= '0;
          if (arp_reply_req) begin
            // Reply wins; any pending request stays pending for later.
            r_reply_ack  <= 1'b1;
            r_target_mac <= arp_rec_source_mac_addr;
            r_target_ip  <= arp_rec_source_ip_addr;
            r_op         <= ARP_REPLY_CODE;
            r_dest_mac   <= arp_rec_source_mac_addr;
            r_tx_req     <= 1'b1;
            r_state      <= ST_WAIT;
          end else if (r_pending || arp_request_req) begin
            r_pending    <= 1'b0;
            r_target_mac <= '0;
            r_target_ip  <= dest_ip_addr;
            r_op         <= ARP_REQUEST_CODE;
            r_dest_mac   <= BROADCAST_MAC;
            r_tx_req     <= 1'b1;
            r_state      <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (mac.mac_tx_ack) begin
            r_tx_req <= 1'b0;
            r_tcnt   <= '0;
            r_cnt    <= '0;
            r_state  <= ST_SEND;
          end else if (r_tcnt == ACK_TIMEOUT - 16'd1) begin
            // No grant in time: drop the frame silently.
            r_tx_req <= 1'b0;
            r_tcnt   <= '0;
            r_state  <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end

        ST_SEND: begin
          if (mac.mac_data_req) begin
            r_data <= w_byte;
            if (r_cnt == LAST_IDX) begin
              r_cnt    <= '0;
              r_tx_end <= 1'b1;
              r_state  <= ST_END;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_END: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_tx_req <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign arp_reply_ack       = r_reply_ack;
  assign mac.arp_tx_req      = r_tx_req;
  assign mac.arp_tx_data     = r_data;
  assign mac.arp_tx_op       = r_op;
  assign mac.arp_tx_dest_mac = r_dest_mac;
  assign mac.arp_tx_end      = r_tx_end;

endmodule
`default_nettype wire

// File: tb/tb_arp_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_arp_tx                                                    |
// | Purpose : Directed self-checking bench for arp_tx: reply, request,     |
// |           simultaneous sources, grant timeout, reply arriving while    |
// |           busy, and reset in the middle of a frame.                    |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_arp_tx;

  localparam int          FB   = 46;
  localparam logic [31:0] LIP  = 32'hC0A8_0002;
  localparam logic [47:0] LMAC = 48'h000A_3501_FEC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dest_ip_addr = '0;
  logic        arp_request_req = 1'b0;
  logic        arp_reply_req = 1'b0;
  logic        arp_reply_ack;
  logic [31:0] src_ip = '0;
  logic [47:0] src_mac = '0;

  int vectors = 0;
  int miscompares = 0;

  arp_tx_if ifc ();

  arp_tx #(
    .FRAME_BYTES (FB),
    .ACK_TIMEOUT (16'd8)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .local_ip_addr           (LIP),
    .local_mac_addr          (LMAC),
    .dest_ip_addr            (dest_ip_addr),
    .arp_request_req         (arp_request_req),
    .arp_reply_req           (arp_reply_req),
    .arp_reply_ack           (arp_reply_ack),
    .arp_rec_source_ip_addr  (src_ip),
    .arp_rec_source_mac_addr (src_mac),
    .mac                     (ifc.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [367:0] obs, input logic [367:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [367:0] exp_frame(input logic [15:0] op, input logic [47:0] tmac,
                                             input logic [31:0] tip);
    return {16'h0001, 16'h0800, 8'h06, 8'h04, op, LMAC, LIP, tmac, tip, 144'h0};
  endfunction

  // Waits for arp_tx_req, grants it, then issues nstrobe byte strobes with
  // `gap` idle cycles after each. Optionally raises arp_reply_req at strobe
  // rise_at. For a full frame, watches three extra cycles and drops
  // arp_reply_req when it is acknowledged.
  task automatic run_frame(input int gap, input int rise_at, input int nstrobe,
                           output logic [367:0] got, output logic [15:0] op_s,
                           output logic [47:0] dm_s, output int nend,
                           output int nack_early, output int nack_late);
    bit seen;
    got = '0; nend = 0; nack_early = 0; nack_late = 0; seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      if (ifc.arp_tx_req) seen = 1'b1;
      else @(negedge clk);
    end
    check("tx_req_seen", 368'(seen), 368'(1));
    op_s = ifc.arp_tx_op;
    dm_s = ifc.arp_tx_dest_mac;
    ifc.mac_tx_ack = 1'b1;
    @(negedge clk);
    ifc.mac_tx_ack = 1'b0;
    check("tx_req_drop", 368'(ifc.arp_tx_req), 368'(0));
    for (int i = 0; i < nstrobe; i++) begin
      if (i == rise_at) arp_reply_req = 1'b1;
      ifc.mac_data_req = 1'b1;
      @(negedge clk);
      ifc.mac_data_req = 1'b0;
      got[367 - 8*i -: 8] = ifc.arp_tx_data;
      if (arp_reply_ack && nend == 0) nack_early++;
      if (ifc.arp_tx_end) nend++;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("data_hold", 368'(ifc.arp_tx_data), 368'(got[367 - 8*i -: 8]));
        if (arp_reply_ack && nend == 0) nack_early++;
        if (ifc.arp_tx_end) nend++;
      end
    end
    if (nstrobe == FB) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (ifc.arp_tx_end) nend++;
        if (arp_reply_ack) begin
          nack_late++;
          arp_reply_req = 1'b0;
        end
      end
    end
  endtask

  logic [367:0] got;
  logic [15:0]  op_s;
  logic [47:0]  dm_s;
  int           nend, na_e, na_l, cnt_req, cnt_end;

  initial begin
    ifc.mac_tx_ack   = 1'b0;
    ifc.mac_data_req = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 368'({ifc.arp_tx_req, arp_reply_ack, ifc.arp_tx_end, ifc.arp_tx_data,
                                 ifc.arp_tx_op, ifc.arp_tx_dest_mac}), 368'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Reply path
    src_ip = 32'hC0A8_0003; src_mac = 48'h1122_3344_5566;
    arp_reply_req = 1'b1;
    @(negedge clk);
    check("reply_ack", 368'(arp_reply_ack), 368'(1));
    check("reply_op", 368'(ifc.arp_tx_op), 368'(16'h0002));
    check("reply_dmac", 368'(ifc.arp_tx_dest_mac), 368'(48'h1122_3344_5566));
    arp_reply_req = 1'b0;
    @(negedge clk);
    check("reply_ack_pulse", 368'(arp_reply_ack), 368'(0));
    run_frame(0, -1, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("reply_frame", got, exp_frame(16'h0002, 48'h1122_3344_5566, 32'hC0A8_0003));
    check("reply_end_cnt", 368'(nend), 368'(1));
    check("reply_op_stable", 368'(ifc.arp_tx_op), 368'(16'h0002));

    // Request path with gapped strobes
    dest_ip_addr = 32'hC0A8_0010;
    arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    check("req_op", 368'(ifc.arp_tx_op), 368'(16'h0001));
    check("req_dmac", 368'(ifc.arp_tx_dest_mac), 368'(48'hFFFF_FFFF_FFFF));
    check("req_no_ack", 368'(arp_reply_ack), 368'(0));
    run_frame(2, -1, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("req_frame", got, exp_frame(16'h0001, 48'h0, 32'hC0A8_0010));
    check("req_end_cnt", 368'(nend), 368'(1));

    // Simultaneous reply and request: reply first, request follows by itself
    src_ip = 32'h0A00_0001; src_mac = 48'hAABB_CCDD_EEFF;
    dest_ip_addr = 32'hC0A8_0020;
    arp_reply_req = 1'b1; arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    check("sim_ack", 368'(arp_reply_ack), 368'(1));
    arp_reply_req = 1'b0;
    run_frame(0, -1, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("sim_first_op", 368'(op_s), 368'(16'h0002));
    check("sim_first_frame", got, exp_frame(16'h0002, 48'hAABB_CCDD_EEFF, 32'h0A00_0001));
    check("sim_first_end", 368'(nend), 368'(1));
    run_frame(0, -1, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("sim_second_op", 368'(op_s), 368'(16'h0001));
    check("sim_second_dmac", 368'(dm_s), 368'(48'hFFFF_FFFF_FFFF));
    check("sim_second_frame", got, exp_frame(16'h0001, 48'h0, 32'hC0A8_0020));
    check("sim_second_end", 368'(nend), 368'(1));

    // Grant timeout: arp_tx_req high exactly 8 cycles, no end pulse
    dest_ip_addr = 32'hC0A8_0030;
    arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    cnt_req = 0; cnt_end = 0;
    for (int c = 0; c < 20; c++) begin
      if (ifc.arp_tx_req) cnt_req++;
      if (ifc.arp_tx_end) cnt_end++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 368'(cnt_req), 368'(8));
    check("timeout_no_end", 368'(cnt_end), 368'(0));
    arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    run_frame(0, -1, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("after_timeout_frame", got, exp_frame(16'h0001, 48'h0, 32'hC0A8_0030));
    check("after_timeout_end", 368'(nend), 368'(1));

    // Reply arriving at byte 20 of a request frame
    dest_ip_addr = 32'hC0A8_0040;
    src_ip = 32'h0A00_00FE; src_mac = 48'h6655_4433_2211;
    arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    run_frame(0, 20, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("busy_req_frame", got, exp_frame(16'h0001, 48'h0, 32'hC0A8_0040));
    check("busy_no_early_ack", 368'(na_e), 368'(0));
    check("busy_ack_after_end", 368'(na_l), 368'(1));
    run_frame(0, -1, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("busy_reply_op", 368'(op_s), 368'(16'h0002));
    check("busy_reply_frame", got, exp_frame(16'h0002, 48'h6655_4433_2211, 32'h0A00_00FE));
    check("busy_reply_end", 368'(nend), 368'(1));

    // Reset at byte 10 with a request pending
    dest_ip_addr = 32'hC0A8_0050;
    arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    run_frame(0, -1, 10, got, op_s, dm_s, nend, na_e, na_l);
    arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_outputs", 368'({ifc.arp_tx_req, arp_reply_ack, ifc.arp_tx_end, ifc.arp_tx_data,
                                    ifc.arp_tx_op, ifc.arp_tx_dest_mac}), 368'(0));
    cnt_req = 0; cnt_end = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifc.arp_tx_req) cnt_req++;
      if (ifc.arp_tx_end) cnt_end++;
    end
    check("midreset_pending_clr", 368'(cnt_req), 368'(0));
    check("midreset_no_end", 368'(cnt_end), 368'(0));
    dest_ip_addr = 32'hC0A8_0060;
    arp_request_req = 1'b1;
    @(negedge clk);
    arp_request_req = 1'b0;
    run_frame(0, -1, FB, got, op_s, dm_s, nend, na_e, na_l);
    check("postreset_frame", got, exp_frame(16'h0001, 48'h0, 32'hC0A8_0060));
    check("postreset_end", 368'(nend), 368'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arp_tx.md
Name: arp_tx

Overview:
- Builds and streams 46-byte ARP payloads (28-byte ARP body plus 18 zero pad bytes) to the MAC transmit path, one byte per MAC data strobe.
- Serves two sources:
  - Reply requests from the ARP receive stage (arp_reply_req plus the latched source IP/MAC).
  - Request (resolve) pulses from the upper layer.
- Sits between the ARP receive/upper-layer logic and the MAC tx framer. It also supplies the destination MAC and ARP operation for the Ethernet header.

Parameters:
- FRAME_BYTES, 46, payload length in bytes including pad; must be ≥ 28.
- ACK_TIMEOUT, 16'd1000, clk cycles to wait for mac_tx_ack before abandoning the frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- local_ip_addr  in  32  own IP, sender protocol address
- local_mac_addr  in  48  own MAC, sender hardware address
- dest_ip_addr  in  32  IP to resolve; sampled when a request is accepted
- arp_request_req  in  1  1-cycle pulse: send ARP request
- arp_reply_req  in  1  level from ARP rx; held until arp_reply_ack
- arp_reply_ack  out  1  1-cycle pulse: reply accepted, fields latched
- arp_rec_source_ip_addr  in  32  target IP for reply
- arp_rec_source_mac_addr  in  48  target MAC for reply
- arp_tx_req  out  1  level: frame ready, to MAC tx
- mac_tx_ack  in  1  1-cycle grant from MAC tx
- mac_data_req  in  1  per-byte strobe from MAC tx
- arp_tx_data  out  8  payload byte
- arp_tx_op  out  16  0x0001 request / 0x0002 reply; stable WAIT..END
- arp_tx_dest_mac  out  48  FF:FF:FF:FF:FF:FF for request, latched target MAC for reply
- arp_tx_end  out  1  1-cycle pulse after last byte

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE; byte counter, timeout counter and pending flag cleared.
  - All outputs 0: arp_tx_data, arp_tx_op, arp_tx_dest_mac, arp_tx_req, arp_reply_ack, arp_tx_end.
  - Reset mid-frame aborts without arp_tx_end.
- Pending request flag:
  - Set by arp_request_req in any state.
  - Cleared when a request is accepted.
  - Multiple pulses while busy collapse into one request.
- States: one-hot IDLE, ARP_WAIT, ARP_SEND, ARP_END.
- IDLE:
  - If arp_reply_req=1: accept the reply. Reply has priority over a pending request; the request stays pending.
    - Pulse arp_reply_ack for one cycle.
    - Latch target MAC/IP from arp_rec_source_*.
    - op=0x0002; dest_mac=target MAC.
  - Else if pending (or arp_request_req this cycle): accept the request.
    - Latch dest_ip_addr; target MAC=0.
    - op=0x0001; dest_mac=all-ones.
  - Either acceptance → ARP_WAIT on the next edge.
- ARP_WAIT:
  - arp_tx_req=1.
  - mac_tx_ack → ARP_SEND; arp_tx_req drops in the same edge.
  - Timeout counter increments each cycle; reaching ACK_TIMEOUT-1 without ack → IDLE, frame dropped, no arp_tx_end.
- ARP_SEND:
  - On each mac_data_req=1 cycle, arp_tx_data is registered with byte[cnt] and cnt increments. Data is valid the cycle after the strobe.
  - mac_data_req=0 holds cnt and data.
  - Strobe at cnt==FRAME_BYTES-1 → ARP_END.
- ARP_END: arp_tx_end=1 for one cycle; → IDLE; cnt=0.
- Byte map (big-endian fields):
  - 0-1 = 0x0001 (HTYPE)
  - 2-3 = 0x0800 (PTYPE)
  - 4 = 0x06 (HLEN)
  - 5 = 0x04 (PLEN)
  - 6-7 = op
  - 8-13 = local_mac_addr
  - 14-17 = local_ip_addr
  - 18-23 = latched target MAC
  - 24-27 = latched target IP
  - 28..FRAME_BYTES-1 = 0x00
- local_* are sampled live during SEND; they must be static.
- arp_reply_req arriving while busy is not acked until the state returns to IDLE. It is never dropped, because the level is held upstream.
- arp_reply_ack is never asserted outside IDLE.
- Minimum IDLE dwell is one cycle between frames.

Decomposition:
- Shared package `arp_pkg`:
  - ARP_REQUEST_CODE=16'h0001, ARP_REPLY_CODE=16'h0002
  - ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800
  - HLEN/PLEN constants
  - BROADCAST_MAC=48'hFFFF_FFFF_FFFF
  - State encodings
- Single module; the byte-select mux stays inline, no sub-module.

Test Plan:
- Reply path:
  - Stimulus: local 192.168.0.2 / 00:0A:35:01:FE:C0; arp_reply_req=1 with source 192.168.0.3 / 11:22:33:44:55:66; ack immediately; 46 strobes back-to-back.
  - Required: arp_reply_ack one cycle after req; op=0x0002; dest_mac=112233445566; bytes 6-7=00 02, 18-23=11 22 33 44 55 66, 24-27=C0 A8 00 03, 28-45=00; one arp_tx_end.
- Request path:
  - Stimulus: arp_request_req pulse, dest_ip C0A80010; strobes gapped (1 on / 2 off).
  - Required: op=0x0001; dest_mac all-ones; bytes 18-23=00; 24-27=C0 A8 00 10; data held during gaps; exactly 46 bytes.
- Simultaneous:
  - Stimulus: reply and request in the same cycle.
  - Required: reply frame first, then request frame with no further pulse; two arp_tx_end pulses in order reply, request.
- Timeout:
  - Stimulus: ACK_TIMEOUT=8, mac_tx_ack never asserted.
  - Required: arp_tx_req high exactly 8 cycles; return to IDLE; no arp_tx_end; next request proceeds normally.
- Busy arrival:
  - Stimulus: arp_reply_req rises at byte 20 of a request frame.
  - Required: ack only after arp_tx_end and the return to IDLE; second frame correct.
- Reset mid-frame:
  - Stimulus: rst_n low one cycle at byte 10.
  - Required: all outputs 0 next edge; pending cleared; no arp_tx_end; fresh request afterwards starts at byte 0.
